fpga_top_mul_share_arb: RTL and testbench

Round-robin arbiter and sequencer that time-shares one 10-bit × 10-bit unsigned multiplier (16-bit truncated product) among `NUM_REQ` HLS datapath requesters inside `fpga_top`. The block accepts operand pairs over per-requester valid/ready handshakes and grants one request per cycle. It pushes the granted request through a two-stage pipeline (operand register, then product register) and returns each product with the ID of the requester that issued it, under downstream backpressure.

---
 rtl/fpga_top_mul_share_pkg.sv | 15 +
 rtl/fpga_top_mul_share_dp.sv | 13 +
 rtl/fpga_top_mul_share_arb.sv | 117 +++++++++++
 tb/tb_fpga_top_mul_share_arb.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fpga_top_mul_share_pkg.sv
// Shared types and helpers for the time-shared multiplier arbiter.
package fpga_top_mul_share_pkg;

    localparam int unsigned OP_W   = 10;
    localparam int unsigned PROD_W = 16;

    typedef logic [OP_W-1:0]   op_t;
    typedef logic [PROD_W-1:0] prod_t;

    // Next round-robin index after idx, wrapping at n.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/fpga_top_mul_share_dp.sv
// Combinational 10x10 unsigned multiplier returning the low 16 product bits.
module fpga_top_mul_share_dp
    import fpga_top_mul_share_pkg::*;
(
    input  op_t   a,
    input  op_t   b,
    output prod_t p
);

    // Multiplying in the 16-bit result width yields exactly the low 16 bits of the 20-bit product.
    assign p = PROD_W'(a) * PROD_W'(b);

endmodule

// File: rtl/fpga_top_mul_share_arb.sv
// Round-robin arbiter feeding a shared two-stage multiplier pipeline with result backpressure.
module fpga_top_mul_share_arb
    import fpga_top_mul_share_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*OP_W-1:0] req_a,
    input  logic [NUM_REQ*OP_W-1:0] req_b,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    res_valid,
    output prod_t                   res_data,
    output logic [ID_W-1:0]         res_id,
    input  logic                    res_ready,
    output logic [1:0]              in_flight
);

    logic            v1_q, v2_q;
    op_t             a1_q, b1_q;
    logic [ID_W-1:0] id1_q, id2_q;
    prod_t           p2_q;
    logic [ID_W-1:0] rr_q, rr_d;

    logic            adv2_c, adv1_c, accept_c;
    logic            gnt_vld;
    logic [ID_W-1:0] gnt_idx, cand;
    op_t             a_arr [NUM_REQ];
    op_t             b_arr [NUM_REQ];
    prod_t           prod_c;

    // Stage advance: output drains or is empty; S1 moves whenever S2 can take it or S1 is a bubble.
    assign adv2_c   = !v2_q || res_ready;
    assign adv1_c   = !v1_q || adv2_c;
    assign accept_c = gnt_vld && adv1_c;

    // Round-robin search starting at the pointer; depends only on valids and the pointer.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((32'(rr_q) + k) % NUM_REQ);
            if (!gnt_vld && req_valid[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // One-hot ready to the granted requester, only when S1 can accept.
    always_comb begin
        req_ready = '0;
        if (accept_c) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // Unpack per-requester operand lanes.
    always_comb begin
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            a_arr[k] = req_a[k*OP_W +: OP_W];
            b_arr[k] = req_b[k*OP_W +: OP_W];
        end
    end

    // Pointer moves past the winner on every accept.
    always_comb begin
        rr_d = rr_q;
        if (accept_c) begin
            rr_d = ID_W'(rr_next(32'(gnt_idx), NUM_REQ));
        end
    end

    fpga_top_mul_share_dp u_dp (
        .a (a1_q),
        .b (b1_q),
        .p (prod_c)
    );

    // Pipeline registers and round-robin pointer.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            v1_q  <= 1'b0;
            a1_q  <= '0;
            b1_q  <= '0;
            id1_q <= '0;
            v2_q  <= 1'b0;
            p2_q  <= '0;
            id2_q <= '0;
            rr_q  <= '0;
        end else begin
            rr_q <= rr_d;
            if (adv2_c) begin
                v2_q  <= v1_q;
                p2_q  <= prod_c;
                id2_q <= id1_q;
            end
            if (adv1_c) begin
                v1_q <= gnt_vld;
                if (gnt_vld) begin
                    a1_q  <= a_arr[gnt_idx];
                    b1_q  <= b_arr[gnt_idx];
                    id1_q <= gnt_idx;
                end
            end
        end
    end

    assign res_valid = v2_q;
    assign res_data  = p2_q;
    assign res_id    = id2_q;
    assign in_flight = 2'(v1_q) + 2'(v2_q);

endmodule

// File: tb/tb_fpga_top_mul_share_arb.sv
// Directed bench for the shared-multiplier arbiter: vector table plus multi-cycle sequences.
module tb_fpga_top_mul_share_arb;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic [3:0]  req_valid;
    logic [39:0] req_a, req_b;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic [15:0] res_data;
    logic [1:0]  res_id;
    logic        res_ready;
    logic [1:0]  in_flight;

    int n_vec = 0;
    int n_err = 0;

    always #5 ap_clk = ~ap_clk;

    fpga_top_mul_share_arb #(.NUM_REQ(4), .ID_W(2)) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ready (res_ready),
        .in_flight (in_flight)
    );

    typedef struct {
        logic [3:0]  valid;
        logic [39:0] a;
        logic [39:0] b;
        logic        rr;
        logic [3:0]  erdy;
        logic        erv;
        logic [15:0] edata;
        logic [1:0]  eid;
        logic [1:0]  eif;
    } vec_t;

    vec_t tbl [10];

    function automatic vec_t mk(input logic [3:0] valid, input logic [39:0] a, input logic [39:0] b,
                                input logic rr, input logic [3:0] erdy, input logic erv,
                                input logic [15:0] edata, input logic [1:0] eid, input logic [1:0] eif);
        vec_t v;
        v.valid = valid; v.a = a; v.b = b; v.rr = rr; v.erdy = erdy;
        v.erv = erv; v.edata = edata; v.eid = eid; v.eif = eif;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    initial begin
        logic [15:0] q [$];
        int          a0, b0, pushed, popped, cyc, gi;
        logic        saw_full, prev_hold, acc;
        logic [15:0] prev_data;
        logic [1:0]  prev_id;

        // Single request, wrap-around, truncation.
        tbl[0] = mk(4'b0100, {10'd0, 10'd1023, 10'd0, 10'd0}, {10'd0, 10'd1023, 10'd0, 10'd0}, 1'b1, 4'b0100, 1'b0, 16'h0, 2'd0, 2'd0);
        tbl[1] = mk(4'b0000, 40'd0, 40'd0, 1'b1, 4'b0000, 1'b0, 16'h0, 2'd0, 2'd1);
        tbl[2] = mk(4'b0000, 40'd0, 40'd0, 1'b1, 4'b0000, 1'b1, 16'hF801, 2'd2, 2'd1);
        tbl[3] = mk(4'b1001, {10'd9, 10'd0, 10'd0, 10'd5}, {10'd11, 10'd0, 10'd0, 10'd7}, 1'b1, 4'b1000, 1'b0, 16'h0, 2'd0, 2'd0);
        tbl[4] = mk(4'b0001, {10'd0, 10'd0, 10'd0, 10'd5}, {10'd0, 10'd0, 10'd0, 10'd7}, 1'b1, 4'b0001, 1'b0, 16'h0, 2'd0, 2'd1);
        tbl[5] = mk(4'b0000, 40'd0, 40'd0, 1'b1, 4'b0000, 1'b1, 16'd99, 2'd3, 2'd2);
        tbl[6] = mk(4'b0000, 40'd0, 40'd0, 1'b1, 4'b0000, 1'b1, 16'd35, 2'd0, 2'd1);
        tbl[7] = mk(4'b0010, {10'd0, 10'd0, 10'd512, 10'd0}, {10'd0, 10'd0, 10'd256, 10'd0}, 1'b1, 4'b0010, 1'b0, 16'h0, 2'd0, 2'd0);
        tbl[8] = mk(4'b0000, 40'd0, 40'd0, 1'b1, 4'b0000, 1'b0, 16'h0, 2'd0, 2'd1);
        tbl[9] = mk(4'b0000, 40'd0, 40'd0, 1'b1, 4'b0000, 1'b1, 16'h0000, 2'd1, 2'd1);

        ap_rst_n  = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b0;
        #2;
        chk("reset_res_valid", 32'(res_valid), 0);
        chk("reset_res_data",  32'(res_data),  0);
        chk("reset_res_id",    32'(res_id),    0);
        chk("reset_in_flight", 32'(in_flight), 0);
        chk("reset_req_ready", 32'(req_ready), 0);
        #10;
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;

        for (int i = 0; i < 10; i++) begin
            req_valid = tbl[i].valid;
            req_a     = tbl[i].a;
            req_b     = tbl[i].b;
            res_ready = tbl[i].rr;
            #1;
            chk($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(tbl[i].erdy));
            chk($sformatf("v%0d_res_valid", i), 32'(res_valid), 32'(tbl[i].erv));
            chk($sformatf("v%0d_in_flight", i), 32'(in_flight), 32'(tbl[i].eif));
            if (tbl[i].erv) begin
                chk($sformatf("v%0d_res_data", i), 32'(res_data), 32'(tbl[i].edata));
                chk($sformatf("v%0d_res_id", i),   32'(res_id),   32'(tbl[i].eid));
            end
            @(posedge ap_clk); #1;
        end

        // Backpressure: requester 0 streams changing operands, output stalled for 5 cycles.
        a0 = 20; b0 = 30; pushed = 0; popped = 0;
        saw_full = 1'b0; prev_hold = 1'b0; prev_data = '0; prev_id = '0;
        for (int c = 0; c < 20; c++) begin
            res_ready = (c >= 5);
            req_valid = (c < 12) ? 4'b0001 : 4'b0000;
            req_a     = {30'd0, 10'(a0)};
            req_b     = {30'd0, 10'(b0)};
            #1;
            if (prev_hold) begin
                chk("bp_hold_valid", 32'(res_valid), 1);
                chk("bp_hold_data",  32'(res_data),  32'(prev_data));
                chk("bp_hold_id",    32'(res_id),    32'(prev_id));
            end
            if (in_flight == 2'd2) saw_full = 1'b1;
            if (in_flight == 2'd2 && !res_ready) chk("bp_ready_blocked", 32'(req_ready), 0);
            if (res_valid && res_ready) begin
                if (q.size() == 0) chk("bp_spurious_result", 1, 0);
                else begin
                    chk("bp_data", 32'(res_data), 32'(q.pop_front()));
                    chk("bp_id",   32'(res_id),   0);
                end
                popped++;
            end
            acc = req_ready[0];
            if (acc) begin
                q.push_back(16'(a0 * b0));
                pushed++;
            end
            prev_hold = res_valid && !res_ready;
            prev_data = res_data;
            prev_id   = res_id;
            @(posedge ap_clk); #1;
            if (acc) begin
                a0 = a0 + 1;
                b0 = b0 + 3;
            end
        end
        chk("bp_queue_drained", 32'(q.size()), 0);
        chk("bp_count",         32'(popped),   32'(pushed));
        chk("bp_accepts",       32'(pushed),   9);
        chk("bp_reached_full",  32'(saw_full), 1);

        // Reset mid-stream with both stages occupied.
        req_valid = 4'b1111;
        req_a     = {10'd4, 10'd3, 10'd2, 10'd1};
        req_b     = {10'd3, 10'd3, 10'd3, 10'd3};
        res_ready = 1'b0;
        #1;
        cyc = 0;
        while (in_flight != 2'd2 && cyc < 6) begin
            @(posedge ap_clk); #2;
            cyc++;
        end
        chk("rst_setup_full", 32'(in_flight), 2);
        ap_rst_n = 1'b0;
        #1;
        chk("rst_async_res_valid", 32'(res_valid), 0);
        chk("rst_async_res_data",  32'(res_data),  0);
        chk("rst_async_res_id",    32'(res_id),    0);
        chk("rst_async_in_flight", 32'(in_flight), 0);
        @(negedge ap_clk);
        ap_rst_n  = 1'b1;
        res_ready = 1'b1;
        #1;

        // Round-robin at full throughput from the reset pointer.
        for (int c = 0; c < 12; c++) begin
            chk($sformatf("rr%0d_req_ready", c), 32'(req_ready), 32'(1 << (c % 4)));
            if (c < 2) begin
                chk($sformatf("rr%0d_res_valid", c), 32'(res_valid), 0);
            end else begin
                gi = (c - 2) % 4;
                chk($sformatf("rr%0d_res_valid", c), 32'(res_valid), 1);
                chk($sformatf("rr%0d_res_id", c),    32'(res_id),    32'(gi));
                chk($sformatf("rr%0d_res_data", c),  32'(res_data),  32'(3 * (gi + 1)));
                chk($sformatf("rr%0d_in_flight", c), 32'(in_flight), 2);
            end
            @(posedge ap_clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
